// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache controller: FSM state encoding and request-type constants.
// Pure declarations; no logic, no latency.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_WRITEBACK,
        ST_ALLOCATE,
        ST_DONE
    } ctrl_state_t;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/cache_perf_counter.sv
// Saturating event counter: +1 per cycle with inc_i high, holds at all-ones.
// Count visible one cycle after the event; synchronous rst wins over inc_i.
module cache_perf_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cache_controller.sv
// Cache control FSM steering cache_memory enables and a req/ready main-memory handshake.
// Hit completes 2 cycles after acceptance; misses wait on mem_ready, no CPU queueing.
module cache_controller
    import cache_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req_valid,
    input  logic                 cpu_req_type,
    output logic                 cpu_ready,
    output logic                 cpu_done,
    input  logic                 hit,
    input  logic                 dirty_bit,
    output logic                 read_en_cache,
    output logic                 write_en_cache,
    output logic                 read_en_mem,
    output logic                 write_en_mem,
    output logic                 mem_req,
    output logic                 mem_we,
    input  logic                 mem_ready,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    ctrl_state_t state_q, state_d;
    logic        type_q, type_d;
    logic        refilled_q, refilled_d;
    logic        hit_inc, miss_inc, wb_inc;

    always_comb begin
        state_d        = state_q;
        type_d         = type_q;
        refilled_d     = refilled_q;
        cpu_ready      = 1'b0;
        cpu_done       = 1'b0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        wb_inc         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req_valid) begin
                    type_d     = cpu_req_type;
                    refilled_d = 1'b0;
                    state_d    = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                read_en_cache  = (type_q == REQ_READ);
                write_en_cache = (type_q == REQ_WRITE) && hit;
                if (hit) begin
                    // Only first-look hits count; the post-refill hit is the same request.
                    hit_inc = !refilled_q;
                    state_d = ST_DONE;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = dirty_bit ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                write_en_mem = 1'b1;
                if (mem_ready) begin
                    wb_inc  = 1'b1;
                    state_d = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    read_en_mem = 1'b1;
                    refilled_d  = 1'b1;
                    state_d     = ST_COMPARE;
                end
            end
            ST_DONE: begin
                cpu_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            type_q     <= REQ_READ;
            refilled_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            refilled_q <= refilled_d;
        end
    end

    cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (hit_inc),
        .count_o (hit_count)
    );

    cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (miss_inc),
        .count_o (miss_count)
    );

    cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wb_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (wb_inc),
        .count_o (wb_count)
    );

endmodule
